led_pwm_dimmer: RTL and testbench

LED_PWM_DIMMER -- requirements
Module: led_pwm_dimmer

---
 rtl/led_pkg.sv | 33 +++
 rtl/led_pwm_dimmer_if.sv | 11 +
 rtl/led_pwm_timebase.sv | 42 ++++
 rtl/led_pwm_dimmer.sv | 130 +++++++++++++
 tb/tb_led_pwm_dimmer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared register map, field widths, reset values and breathe-state encoding for the LED PWM dimmer.
// Everything here is constant; no logic.
package led_pkg;
  localparam int LED_W  = 32;
  localparam int CFG_W  = 32;
  localparam int ADDR_W = 2;
  localparam int PWM_W  = 8;
  localparam int DUTY_W = 8;
  localparam int STEP_W = 24;

  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_DUTY    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STEPDIV = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd3;

  // 255-cycle frame: counter runs 0..254
  localparam logic [PWM_W-1:0]  PWM_LAST    = 8'd254;
  localparam logic [DUTY_W-1:0] DUTY_MAX    = 8'hFF;
  localparam logic [DUTY_W-1:0] DUTY_MIN    = 8'h00;
  localparam logic [DUTY_W-1:0] DUTY_RST    = 8'hFF;
  localparam logic [STEP_W-1:0] STEPDIV_RST = 24'h0000FF;
  localparam logic [LED_W-1:0]  LED_OFF     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2
  } breathe_state_t;

  function automatic logic [CFG_W-1:0] status_word(breathe_state_t st, logic [DUTY_W-1:0] duty);
    return {22'b0, st, duty};
  endfunction
endpackage

// File: rtl/led_pwm_dimmer_if.sv
// Configuration register bus of the LED PWM dimmer: one write per strobe cycle,
// combinational read data for the selected register; no backpressure.
interface led_pwm_dimmer_if;
  logic                        cfg_we;
  logic [led_pkg::ADDR_W-1:0]  cfg_addr;
  logic [led_pkg::CFG_W-1:0]   cfg_wdata;
  logic [led_pkg::CFG_W-1:0]   cfg_rdata;

  modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/led_pwm_timebase.sv
// Free-running 255-cycle PWM frame counter plus the breathe step divider (frames per duty step).
// frame_end and step_pulse are combinational from registered state; no backpressure.
module led_pwm_timebase
  import led_pkg::*;
(
  input  logic              clk_in,
  input  logic              sys_rstn,
  input  logic              step_run,
  input  logic              step_clr,
  input  logic [STEP_W-1:0] stepdiv,
  output logic [PWM_W-1:0]  pwm_cnt,
  output logic              frame_end,
  output logic              step_pulse
);
  logic [STEP_W-1:0] step_cnt;
  logic              step_hit;

  assign frame_end  = (pwm_cnt == PWM_LAST);
  assign step_hit   = frame_end && step_run && (step_cnt == stepdiv);
  // A clear in the same cycle restarts the interval instead of stepping
  assign step_pulse = step_hit && !step_clr;

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pwm_cnt <= '0;
    end else if (frame_end) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      step_cnt <= '0;
    end else if (step_clr) begin
      step_cnt <= '0;
    end else if (frame_end && step_run) begin
      step_cnt <= step_hit ? '0 : step_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pwm_dimmer.sv
// Dims an active-low 32-bit LED pattern with a 255-cycle PWM, optionally breathing the duty up/down.
// Pattern latency 1 cycle; duty changes land only on frame boundaries; config bus never stalls.
module led_pwm_dimmer
  import led_pkg::*;
(
  input  logic             clk_in,
  input  logic             sys_rstn,
  input  logic [LED_W-1:0] led_in,
  output logic [LED_W-1:0] led_light,
  led_pwm_dimmer_if.slave  cfg
);
  logic [LED_W-1:0]  led_q;
  logic [1:0]        ctrl_q;
  logic [DUTY_W-1:0] duty_q;
  logic [STEP_W-1:0] stepdiv_q;
  logic [DUTY_W-1:0] duty_eff_q, duty_eff_d;
  breathe_state_t    state_q, state_d;

  logic              enable, breathe;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              frame_end, step_pulse, step_run, step_clr, stepdiv_we;
  logic [CFG_W-1:0]  rdata;

  assign enable     = ctrl_q[0];
  assign breathe    = ctrl_q[1];
  assign stepdiv_we = cfg.cfg_we && (cfg.cfg_addr == ADDR_STEPDIV);
  assign step_run   = (state_q != ST_STATIC) && breathe;
  assign step_clr   = stepdiv_we || (state_q == ST_STATIC) || (frame_end && !breathe);

  led_pwm_timebase u_timebase (
    .clk_in     (clk_in),
    .sys_rstn   (sys_rstn),
    .step_run   (step_run),
    .step_clr   (step_clr),
    .stepdiv    (stepdiv_q),
    .pwm_cnt    (pwm_cnt),
    .frame_end  (frame_end),
    .step_pulse (step_pulse)
  );

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      led_q     <= LED_OFF;
      ctrl_q    <= '0;
      duty_q    <= DUTY_RST;
      stepdiv_q <= STEPDIV_RST;
    end else begin
      led_q <= led_in;
      if (cfg.cfg_we) begin
        case (cfg.cfg_addr)
          ADDR_CTRL:    ctrl_q    <= cfg.cfg_wdata[1:0];
          ADDR_DUTY:    duty_q    <= cfg.cfg_wdata[DUTY_W-1:0];
          ADDR_STEPDIV: stepdiv_q <= cfg.cfg_wdata[STEP_W-1:0];
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= ST_STATIC;
      duty_eff_q <= DUTY_RST;
    end else begin
      state_q    <= state_d;
      duty_eff_q <= duty_eff_d;
    end
  end

  // A step from the end value reverses direction, so 255 (or 0) is shown for one full interval
  always_comb begin
    state_d    = state_q;
    duty_eff_d = duty_eff_q;
    if (frame_end) begin
      if (!breathe) begin
        state_d    = ST_STATIC;
        duty_eff_d = duty_q;
      end else begin
        case (state_q)
          ST_STATIC: begin
            state_d    = ST_UP;
            duty_eff_d = duty_q;
          end
          ST_UP: begin
            if (step_pulse) begin
              if (duty_eff_q == DUTY_MAX) begin
                state_d    = ST_DOWN;
                duty_eff_d = DUTY_MAX - 1'b1;
              end else begin
                duty_eff_d = duty_eff_q + 1'b1;
              end
            end
          end
          ST_DOWN: begin
            if (step_pulse) begin
              if (duty_eff_q == DUTY_MIN) begin
                state_d    = ST_UP;
                duty_eff_d = DUTY_MIN + 1'b1;
              end else begin
                duty_eff_d = duty_eff_q - 1'b1;
              end
            end
          end
          default: state_d = ST_STATIC;
        endcase
      end
    end
  end

  // Lit bits pass only inside the duty window; unlit bits stay high either way
  always_comb begin
    led_light = led_q;
    if (enable && !(pwm_cnt < duty_eff_q)) begin
      led_light = LED_OFF;
    end
  end

  always_comb begin
    rdata = '0;
    case (cfg.cfg_addr)
      ADDR_CTRL:    rdata = {30'b0, ctrl_q};
      ADDR_DUTY:    rdata = {24'b0, duty_q};
      ADDR_STEPDIV: rdata = {8'b0, stepdiv_q};
      ADDR_STATUS:  rdata = status_word(state_q, duty_eff_q);
      default:      rdata = '0;
    endcase
  end

  assign cfg.cfg_rdata = rdata;
endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer: directed checks with literal expectations plus
// randomized traffic compared every cycle against an integer behavioural model.
module tb_led_pwm_dimmer;
  logic        clk_in   = 1'b0;
  logic        sys_rstn = 1'b1;
  logic [31:0] led_in   = 32'h0;
  logic [31:0] led_light;

  led_pwm_dimmer_if cfg();

  led_pwm_dimmer dut (
    .clk_in    (clk_in),
    .sys_rstn  (sys_rstn),
    .led_in    (led_in),
    .led_light (led_light),
    .cfg       (cfg)
  );

  always #5 clk_in = ~clk_in;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     chk_on = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Behavioural model: frame position, mode (0 static, 1 up, 2 down), effective duty, frames counted
  int          m_cnt, m_mode, m_deff, m_steps, m_duty, m_stepdiv;
  logic [1:0]  m_ctrl;
  logic [31:0] m_led;

  always @(posedge clk_in or negedge sys_rstn) begin
    int nm, nd, ns, dir;
    bit fe, wr_sd;
    if (!sys_rstn) begin
      m_cnt <= 0; m_mode <= 0; m_deff <= 255; m_steps <= 0;
      m_duty <= 255; m_stepdiv <= 255; m_ctrl <= 2'b00; m_led <= 32'hFFFF_FFFF;
    end else begin
      fe    = (m_cnt == 254);
      wr_sd = cfg.cfg_we && (cfg.cfg_addr == 2'd2);
      nm = m_mode; nd = m_deff; ns = m_steps;
      if (m_mode == 0 || wr_sd) ns = 0;
      if (fe) begin
        if (!m_ctrl[1]) begin
          nm = 0; nd = m_duty; ns = 0;
        end else if (m_mode == 0) begin
          nm = 1; nd = m_duty;
        end else if (!wr_sd) begin
          if (m_steps == m_stepdiv) begin
            ns  = 0;
            dir = (m_mode == 1) ? 1 : -1;
            nd  = m_deff + dir;
            if (nd > 255 || nd < 0) begin
              nm = (m_mode == 1) ? 2 : 1;
              nd = m_deff - dir;
            end
          end else begin
            ns = m_steps + 1;
          end
        end
      end
      m_mode  <= nm;
      m_deff  <= nd;
      m_steps <= ns;
      m_cnt   <= fe ? 0 : m_cnt + 1;
      m_led   <= led_in;
      if (cfg.cfg_we) begin
        case (cfg.cfg_addr)
          2'd0: m_ctrl    <= cfg.cfg_wdata[1:0];
          2'd1: m_duty    <= int'(cfg.cfg_wdata[7:0]);
          2'd2: m_stepdiv <= int'(cfg.cfg_wdata[23:0]);
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_light();
    if (!m_ctrl[0]) return m_led;
    return (m_cnt < m_deff) ? m_led : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, m_ctrl};
      2'd1:    return 32'(m_duty);
      2'd2:    return 32'(m_stepdiv);
      default: return (32'(m_mode) << 8) | 32'(m_deff);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  always @(negedge clk_in) begin
    if (chk_on) begin
      check("led_light", led_light, exp_light());
      check("cfg_rdata", cfg.cfg_rdata, exp_rdata(cfg.cfg_addr));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg.cfg_we = 1'b1; cfg.cfg_addr = a; cfg.cfg_wdata = d;
    step(1);
    cfg.cfg_we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    cfg.cfg_addr = a;
    #1;
    d = cfg.cfg_rdata;
  endtask

  // Lands inside the frame_end cycle
  task automatic wait_fe();
    int g = 0;
    while (m_cnt != 254 && g < 400) begin
      step(1);
      g++;
    end
    if (g >= 400) timeout("wait_frame_end");
  endtask

  task automatic next_frame();
    wait_fe();
    step(1);
  endtask

  task automatic measure(output int lows);
    lows = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk_in);
      if (led_light[0] == 1'b0) lows++;
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_change(output longint at);
    logic [31:0] prev, cur;
    int g = 0;
    read_reg(2'd3, prev);
    cur = prev;
    while (cur == prev && g < 2000) begin
      step(1);
      read_reg(2'd3, cur);
      g++;
    end
    if (g >= 2000) timeout("wait_status_change");
    at = cyc;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_seq [5];
    int          lows;
    longint      c0, c1;

    cfg.cfg_we = 1'b0; cfg.cfg_addr = 2'd3; cfg.cfg_wdata = 32'h0;
    #2 sys_rstn = 1'b0;
    #1;
    check("reset_light", led_light, 32'hFFFF_FFFF);
    read_reg(2'd3, rd);
    check("reset_status", rd, 32'h0000_00FF);
    read_reg(2'd1, rd);
    check("reset_duty", rd, 32'h0000_00FF);
    read_reg(2'd2, rd);
    check("reset_stepdiv", rd, 32'h0000_00FF);
    step(3);
    sys_rstn = 1'b1;
    chk_on   = 1'b1;
    led_in   = 32'hFFFF_FFFE;
    check("pass_before", led_light, 32'hFFFF_FFFF);
    step(1);
    check("pass_1cycle", led_light, 32'hFFFF_FFFE);
    step(300);

    cfg_write(2'd0, 32'hFFFF_FFFD);
    read_reg(2'd0, rd);
    check("ctrl_upper_ignored", rd, 32'h0000_0001);
    led_in = 32'h0;
    cfg_write(2'd1, 32'd64);
    next_frame();
    measure(lows);
    check("duty64_lows", 32'(lows), 32'd64);

    wait_fe();
    cfg_write(2'd1, 32'd128);
    measure(lows);
    check("fe_write_old_duty", 32'(lows), 32'd64);
    measure(lows);
    check("fe_write_new_duty", 32'(lows), 32'd128);

    cfg_write(2'd1, 32'd0);
    next_frame();
    measure(lows);
    check("duty0_lows", 32'(lows), 32'd0);
    cfg_write(2'd1, 32'd255);
    next_frame();
    measure(lows);
    check("duty255_lows", 32'(lows), 32'd255);
    check("duty255_light", led_light, 32'h0);

    exp_seq = '{32'h1FD, 32'h1FE, 32'h1FF, 32'h2FE, 32'h2FD};
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd1, 32'hABCD_12FD);
    read_reg(2'd1, rd);
    check("duty_upper_ignored", rd, 32'h0000_00FD);
    cfg_write(2'd0, 32'd3);
    for (int k = 0; k < 5; k++) begin
      next_frame();
      read_reg(2'd3, rd);
      check($sformatf("breathe_status_%0d", k), rd, exp_seq[k]);
    end
    cfg_write(2'd0, 32'd1);
    next_frame();
    read_reg(2'd3, rd);
    check("breathe_off_static", rd, 32'h0FD);

    cfg_write(2'd1, 32'd10);
    cfg_write(2'd2, 32'hFF00_0003);
    read_reg(2'd2, rd);
    check("stepdiv_upper_ignored", rd, 32'h0000_0003);
    cfg_write(2'd0, 32'd3);
    next_frame();
    next_frame();
    wait_change(c0);
    wait_change(c1);
    check("stepdiv3_interval", 32'(c1 - c0), 32'd1020);
    c0 = c1;
    step(599);
    cfg_write(2'd2, 32'd3);
    wait_change(c1);
    check("stepdiv_restart_interval", 32'(c1 - c0), 32'd1530);

    cfg_write(2'd0, 32'd1);
    cfg_write(2'd1, 32'd255);
    next_frame();
    step(1);
    check("lit_before_reset", led_light, 32'h0);
    #2 sys_rstn = 1'b0;
    #1;
    check("reset_async_light", led_light, 32'hFFFF_FFFF);
    step(3);
    sys_rstn = 1'b1;
    read_reg(2'd3, rd);
    check("status_after_reset", rd, 32'h0000_00FF);

    for (int n = 0; n < 6000; n++) begin
      led_in       = $urandom;
      cfg.cfg_addr = 2'($urandom_range(0, 3));
      cfg.cfg_we   = ($urandom_range(0, 15) == 0);
      case (cfg.cfg_addr)
        2'd1: cfg.cfg_wdata = ($urandom & 32'hFFFF_FF00) |
                              (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3))
                                                           : 32'($urandom_range(251, 255)));
        2'd2: cfg.cfg_wdata = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 2));
        default: cfg.cfg_wdata = $urandom;
      endcase
      if ($urandom_range(0, 2999) == 0) begin
        sys_rstn = 1'b0;
        #2 sys_rstn = 1'b1;
      end
      step(1);
    end
    cfg.cfg_we = 1'b0;
    step(2);
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
